// File: rtl/seq_pattern_trigger.sv
// seq_pattern_trigger
//   Masked pattern comparator with a consecutive-beat run counter and an
//   arm/clear control FSM. trig_out fires after DEPTH consecutive matching
//   valid beats while ARMED. Idle cycles (in_valid = 0) between beats do not
//   break a run. The match is computed as ((in_data ^ PATTERN) & MASK) == 0.
//
//   Parameters: WIDTH (data width), DEPTH (1..255), PATTERN, MASK.
//
//   Optional feature, enabled with the macro SEQ_TRIG_PULSE_EN:
//     defined   - pulse mode: trig_out is high for one cycle per run, and the
//                 FSM drops straight back to ARMED with the count cleared.
//     undefined - sticky mode: FIRED holds trig_out high until clear or reset.
//
//   The priority inside a single cycle is clear > arm > data.

module seq_pattern_trigger #(
  parameter int               WIDTH   = 32,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(32'h331D58BA),
  parameter logic [WIDTH-1:0] MASK    = '1,
  localparam int              CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             arm,
  input  logic             clear,
  output logic             trig_out,
  output logic             armed,
  output logic [CW-1:0]    match_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  state_t          state, state_d;
  logic [CW-1:0]   cnt_d;
  logic            trig_d;
  logic            hit;

  // Masked compare of the current beat; qualified by in_valid in the FSM.
  assign hit = ((in_data ^ PATTERN) & MASK) == '0;

  // Next-state, next-count and next-trigger decode (clear > arm > data).
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d = state;
    cnt_d   = match_cnt;
    trig_d  = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (arm && (state != ST_FIRED)) begin
      // Arming from IDLE, or re-arming while ARMED, restarts the run. The
      // beat presented in this cycle is not counted.
      state_d = ST_ARMED;
      cnt_d   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Data is ignored until the block is armed.
        end
        ST_ARMED: begin
          if (in_valid) begin
            if (hit) begin
              if (match_cnt == CNT_LAST) begin
                trig_d = 1'b1;
`ifdef SEQ_TRIG_PULSE_EN
                state_d = ST_ARMED;
                cnt_d   = '0;
`else
                state_d = ST_FIRED;
                cnt_d   = CNT_FULL;
`endif
              end else begin
                cnt_d = match_cnt + CW'(1);
              end
            end else begin
              // A missed beat ends the run. It never starts a new one.
              cnt_d = '0;
            end
          end
        end
        ST_FIRED: begin
          // Sticky: hold the trigger and the full count. Data and arm are ignored.
          trig_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, count and output registers. An asynchronous reset clears all progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      match_cnt <= '0;
      trig_out  <= 1'b0;
      armed     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples the values from before the edge, whatever the statement order.
      state     <= state_d;
      match_cnt <= cnt_d;
      trig_out  <= trig_d;
      armed     <= (state_d == ST_ARMED);
    end
  end

endmodule

// File: tb/tb_seq_pattern_trigger.sv
// tb_seq_pattern_trigger
//   Directed bench for seq_pattern_trigger (WIDTH=32, DEPTH=4, default PATTERN
//   and MASK). Expected values are written as {trig_out, armed, match_cnt[2:0]}.
//   If SEQ_TRIG_PULSE_EN is defined for the build, the bench checks pulse-mode
//   expectations.

module tb_seq_pattern_trigger;

  localparam logic [31:0] P = 32'h331D58BA;

`ifdef SEQ_TRIG_PULSE_EN
  localparam logic [4:0] FIRE_ST = 5'b1_1_000;  // one-cycle pulse, back to ARMED
  localparam logic [4:0] POST_ST = 5'b0_1_000;  // cycle after the pulse
`else
  localparam logic [4:0] FIRE_ST = 5'b1_0_100;  // sticky FIRED, count = DEPTH
  localparam logic [4:0] POST_ST = 5'b1_0_100;
`endif
  localparam logic [4:0] IDLE_ST = 5'b0_0_000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        arm;
  logic        clear;
  logic        trig_out;
  logic        armed;
  logic [2:0]  match_cnt;

  int n_cmp = 0;
  int n_err = 0;

  seq_pattern_trigger dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .arm       (arm),
    .clear     (clear),
    .trig_out  (trig_out),
    .armed     (armed),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  // Watchdog so that the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs on the falling edge. Return 1 ns after the next
  // rising edge so that the outputs can be sampled.
  task automatic drive(input logic v, input logic [31:0] d, input logic a, input logic c);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    arm      = a;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; arm = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({trig_out, armed, match_cnt} !== IDLE_ST) begin
      n_err++;
      $display("FAIL reset_held: got %b want %b", {trig_out, armed, match_cnt}, IDLE_ST);
    end
    @(negedge clk); rst_n = 1'b1;
    drive(1'b1, P, 1'b0, 1'b0);
    n_cmp++;
    if ({trig_out, armed, match_cnt} !== IDLE_ST) begin
      n_err++;
      $display("FAIL reset_release: got %b want %b", {trig_out, armed, match_cnt}, IDLE_ST);
    end
  endtask

  task automatic test_basic_fire;
    logic [4:0] exp [5] = '{5'b0_1_000, 5'b0_1_001, 5'b0_1_010, 5'b0_1_011, FIRE_ST};
    for (int i = 0; i < 5; i++) begin
      drive(i != 0, P, i == 0, 1'b0);
      n_cmp++;
      if ({trig_out, armed, match_cnt} !== exp[i]) begin
        n_err++;
        $display("FAIL basic step %0d: got %b want %b", i, {trig_out, armed, match_cnt}, exp[i]);
      end
    end
`ifndef SEQ_TRIG_PULSE_EN
    // Sticky mode: the trigger holds for 10 more cycles, and data is ignored.
    for (int i = 0; i < 10; i++) begin
      drive(i[0], (i[1] ? P : 32'h0), 1'b0, 1'b0);
      n_cmp++;
      if ({trig_out, armed, match_cnt} !== FIRE_ST) begin
        n_err++;
        $display("FAIL basic_hold cycle %0d: got %b want %b", i, {trig_out, armed, match_cnt}, FIRE_ST);
      end
    end
    // Arm is ignored while FIRED.
    drive(1'b1, P, 1'b1, 1'b0);
    n_cmp++;
    if ({trig_out, armed, match_cnt} !== FIRE_ST) begin
      n_err++;
      $display("FAIL arm_in_fired: got %b want %b", {trig_out, armed, match_cnt}, FIRE_ST);
    end
`endif
    drive(1'b0, '0, 1'b0, 1'b1);
    n_cmp++;
    if ({trig_out, armed, match_cnt} !== IDLE_ST) begin
      n_err++;
      $display("FAIL basic_clear: got %b want %b", {trig_out, armed, match_cnt}, IDLE_ST);
    end
  endtask

  // Arm, then P, P, 0, P^MSB, P, P, P, P. Each miss returns the count to 0.
  task automatic test_miss_restart;
    logic [31:0] dat [9] = '{'0, P, P, 32'h0, P ^ 32'h8000_0000, P, P, P, P};
    logic [4:0]  exp [9] = '{5'b0_1_000, 5'b0_1_001, 5'b0_1_010, 5'b0_1_000, 5'b0_1_000,
                             5'b0_1_001, 5'b0_1_010, 5'b0_1_011, FIRE_ST};
    for (int i = 0; i < 9; i++) begin
      drive(i != 0, dat[i], i == 0, 1'b0);
      n_cmp++;
      if ({trig_out, armed, match_cnt} !== exp[i]) begin
        n_err++;
        $display("FAIL miss step %0d: got %b want %b", i, {trig_out, armed, match_cnt}, exp[i]);
      end
    end
    drive(1'b0, '0, 1'b0, 1'b1);
  endtask

  // Four matching beats with 3 idle cycles after each. The count holds across the gaps.
  task automatic test_gaps;
    logic [4:0] exp;
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int b = 1; b <= 4; b++) begin
      drive(1'b1, P, 1'b0, 1'b0);
      exp = (b == 4) ? FIRE_ST : {2'b01, 3'(b)};
      n_cmp++;
      if ({trig_out, armed, match_cnt} !== exp) begin
        n_err++;
        $display("FAIL gaps beat %0d: got %b want %b", b, {trig_out, armed, match_cnt}, exp);
      end
      if (b == 4) exp = POST_ST;
      for (int g = 0; g < 3; g++) begin
        // Data toggles during the gap, but in_valid stays low.
        drive(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        n_cmp++;
        if ({trig_out, armed, match_cnt} !== exp) begin
          n_err++;
          $display("FAIL gaps hold %0d/%0d: got %b want %b", b, g, {trig_out, armed, match_cnt}, exp);
        end
      end
    end
    drive(1'b0, '0, 1'b0, 1'b1);
  endtask

  // With no arm, 8 matching beats have no effect. Clear together with a hit while ARMED goes to IDLE.
  task automatic test_no_arm_and_clear;
    int bad;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, P, 1'b0, 1'b0);
      if ({trig_out, armed, match_cnt} !== IDLE_ST) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL no_arm: got %0d non-idle cycles want 0", bad);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, P, 1'b0, 1'b0);
    drive(1'b1, P, 1'b0, 1'b0);
    drive(1'b1, P, 1'b0, 1'b0);
    n_cmp++;
    if ({trig_out, armed, match_cnt} !== 5'b0_1_011) begin
      n_err++;
      $display("FAIL clear_setup: got %b want %b", {trig_out, armed, match_cnt}, 5'b0_1_011);
    end
    // This would be the firing beat, but clear takes priority.
    drive(1'b1, P, 1'b0, 1'b1);
    n_cmp++;
    if ({trig_out, armed, match_cnt} !== IDLE_ST) begin
      n_err++;
      $display("FAIL clear_with_hit: got %b want %b", {trig_out, armed, match_cnt}, IDLE_ST);
    end
    // Clear beats arm when both arrive in the same cycle.
    drive(1'b1, P, 1'b1, 1'b1);
    n_cmp++;
    if ({trig_out, armed, match_cnt} !== IDLE_ST) begin
      n_err++;
      $display("FAIL clear_over_arm: got %b want %b", {trig_out, armed, match_cnt}, IDLE_ST);
    end
  endtask

  // Arm while ARMED restarts the run, and the beat in that cycle is not counted.
  task automatic test_arm_restart;
    logic [4:0] exp [8] = '{5'b0_1_000, 5'b0_1_001, 5'b0_1_010, 5'b0_1_000,
                            5'b0_1_001, 5'b0_1_010, 5'b0_1_011, FIRE_ST};
    logic       a   [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive(i != 0, P, a[i], 1'b0);
      n_cmp++;
      if ({trig_out, armed, match_cnt} !== exp[i]) begin
        n_err++;
        $display("FAIL rearm step %0d: got %b want %b", i, {trig_out, armed, match_cnt}, exp[i]);
      end
    end
    drive(1'b0, '0, 1'b0, 1'b1);
  endtask

  // Assert the asynchronous reset in the middle of a cycle. Outputs clear with no clock edge.
  task automatic test_async_reset;
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, P, 1'b0, 1'b0);
    drive(1'b1, P, 1'b0, 1'b0);
    drive(1'b1, P, 1'b0, 1'b0);
`ifndef SEQ_TRIG_PULSE_EN
    drive(1'b1, P, 1'b0, 1'b0);
    n_cmp++;
    if ({trig_out, armed, match_cnt} !== FIRE_ST) begin
      n_err++;
      $display("FAIL areset_setup: got %b want %b", {trig_out, armed, match_cnt}, FIRE_ST);
    end
`endif
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({trig_out, armed, match_cnt} !== IDLE_ST) begin
      n_err++;
      $display("FAIL areset_immediate: got %b want %b", {trig_out, armed, match_cnt}, IDLE_ST);
    end
    @(negedge clk); rst_n = 1'b1;
    // After reset the block is IDLE and needs a new arm.
    drive(1'b1, P, 1'b0, 1'b0);
    n_cmp++;
    if ({trig_out, armed, match_cnt} !== IDLE_ST) begin
      n_err++;
      $display("FAIL areset_idle_after: got %b want %b", {trig_out, armed, match_cnt}, IDLE_ST);
    end
  endtask

`ifdef SEQ_TRIG_PULSE_EN
  // Pulse mode: 8 matching beats give two one-cycle pulses, and armed stays 1.
  task automatic test_pulse;
    logic [4:0] exp [10] = '{5'b0_1_000, 5'b0_1_001, 5'b0_1_010, 5'b0_1_011, 5'b1_1_000,
                             5'b0_1_001, 5'b0_1_010, 5'b0_1_011, 5'b1_1_000, 5'b0_1_000};
    for (int i = 0; i < 10; i++) begin
      drive((i != 0) && (i != 9), P, i == 0, 1'b0);
      n_cmp++;
      if ({trig_out, armed, match_cnt} !== exp[i]) begin
        n_err++;
        $display("FAIL pulse step %0d: got %b want %b", i, {trig_out, armed, match_cnt}, exp[i]);
      end
    end
    drive(1'b0, '0, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_fire();
    test_miss_restart();
    test_gaps();
    test_no_arm_and_clear();
    test_arm_restart();
    test_async_reset();
`ifdef SEQ_TRIG_PULSE_EN
    test_pulse();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_pattern_trigger.md
Name: seq_pattern_trigger

Overview:
- Parametrised successor to the fixed 32-bit plaintext comparator.
- Compares a masked WIDTH-bit data beat against PATTERN on every valid cycle.
- Fires a registered trigger only after DEPTH consecutive matching valid beats, under an arm/clear control FSM.
- Sits between the plaintext input bus and the payload logic; exposes status for ChipScope probing.

Parameters:
- WIDTH, 32, data/pattern width in bits.
- DEPTH, 4, consecutive matching valid beats required to fire; legal range 1..255.
- PATTERN, 32'h331D58BA, match value; only the low WIDTH bits are used.
- MASK, all ones (WIDTH bits), compare enable per bit; 0 = don't-care.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data qualifies this cycle.
- in_data  in  WIDTH  plaintext bits under test.
- arm  in  1  one-cycle request: IDLE -> ARMED.
- clear  in  1  one-cycle request: any state -> IDLE, count 0, trigger 0.
- trig_out  out  1  trigger; registered.
- armed  out  1  high while FSM is in ARMED.
- match_cnt  out  CW  current run length, CW = $clog2(DEPTH+1); registered.

Behaviour:
- Reset is asynchronous, active-low; one clock (clk).
- On reset: state IDLE, trig_out = 0, armed = 0, match_cnt = 0.
- Reset mid-run discards all progress.
- Beat match: hit = ((in_data ^ PATTERN) & MASK) == 0, evaluated only when in_valid = 1.
- FSM states: IDLE, ARMED, FIRED.
- IDLE:
  - arm = 1 -> ARMED with match_cnt = 0.
  - Data is ignored.
- ARMED, per clk when in_valid = 1:
  - hit and match_cnt = DEPTH-1 -> FIRED; trig_out = 1 from the next edge.
  - Otherwise hit -> match_cnt + 1.
  - Miss -> match_cnt = 0. There is no partial restart: a missing beat is never counted as the first beat of a new run.
- ARMED with in_valid = 0: match_cnt holds. Gaps between valid beats do not break a run.
- FIRED:
  - trig_out held at 1 and match_cnt held at DEPTH.
  - Data ignored; arm ignored.
- Latency: trig_out rises on the clk edge that samples the DEPTH-th consecutive matching valid beat, i.e. visible the cycle after that beat is presented.
- Priority in one cycle: clear > arm > data.
  - clear with a matching beat -> IDLE, count 0, no fire.
  - arm while ARMED restarts: match_cnt = 0, and the current beat is not counted.
- armed = (state == ARMED), registered with the state.
- DEPTH = 1: the first matching valid beat after arm fires.
- match_cnt never exceeds DEPTH and never wraps.
- MASK = 0: every valid beat matches; fires after DEPTH valid beats.

Optional Feature:
- Macro SEQ_TRIG_PULSE_EN.
- Defined (pulse mode):
  - On the firing edge trig_out is high for exactly one cycle.
  - The FSM returns directly to ARMED with match_cnt = 0, so FIRED is never held.
  - The beat after firing starts a new run.
- Undefined: sticky mode as described in Behaviour; trig_out is held until clear or reset.

Test Plan:
- Reset, arm, 4 valid beats of 32'h331D58BA -> match_cnt 1,2,3,4; trig_out = 1 the cycle after beat 4 and stays 1 for 10 further cycles; armed = 0.
- Arm; beats 331D58BA, 331D58BA, 00000000, then 4×331D58BA -> match_cnt 1,2,0,1,2,3,4; trig fires only after the final beat.
- Arm; 4 matching beats separated by 3 idle cycles each (in_valid = 0) -> count holds across gaps; trig fires after beat 4.
- No arm; 8 matching beats -> trig_out = 0 and match_cnt = 0 throughout. Then clear together with a matching beat while ARMED -> IDLE, count 0, no fire.
- After firing in sticky mode, pulse rst_n low mid-cycle -> trig_out, armed and match_cnt go to 0 immediately, with no clock edge needed.
- SEQ_TRIG_PULSE_EN defined, 8 consecutive matching beats -> trig_out high for exactly one cycle after beats 4 and 8; armed stays 1.
